// File: rtl/egk_debinarizer.sv
// Serial Kth-order Exp-Golomb de-binarizer: unary prefix, terminating 0, k-bit suffix, MSB first.
// Optional macro EGK_DEBIN_SIGNED_EN adds a trailing sign bin for nonzero magnitudes.
module egk_debinarizer #(
  parameter int VAL_BITS = 16,
  parameter int LEN_BITS = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [3:0]          K,
  input  logic                flush,
  input  logic                bin_valid,
  input  logic                bin,
  output logic                bin_ready,
  output logic                val_valid,
  input  logic                val_ready,
  output logic [VAL_BITS-1:0] value,
  output logic [LEN_BITS-1:0] bin_len,
  output logic                err,
  output logic                busy
);
  // k can grow from K=15 up to VAL_BITS before a prefix overflow is flagged
  localparam int KW = $clog2(VAL_BITS + 17);
  localparam logic [KW-1:0] K_LIMIT = KW'(VAL_BITS);

`ifdef EGK_DEBIN_SIGNED_EN
  typedef enum logic [2:0] {IDLE, PREFIX, SUFFIX, SIGN, DONE} state_t;
  localparam state_t TAIL = SIGN;
  localparam logic [VAL_BITS-1:0] HALF = {1'b1, {(VAL_BITS-1){1'b0}}};
`else
  typedef enum logic [2:0] {IDLE, PREFIX, SUFFIX, DONE} state_t;
  localparam state_t TAIL = DONE;
`endif

  state_t state, state_nx;
  logic [KW-1:0] k, k_nx, cnt, cnt_nx;
  logic [VAL_BITS-1:0] acc, acc_nx, suff, suff_nx, val_q, val_nx, suff_sh;
  logic [LEN_BITS-1:0] len, len_nx;
  logic ovf, ovf_nx, err_q, err_nx;
  logic accept, sfx_err;
  logic [VAL_BITS:0] pow, psum, fsum;

`ifdef EGK_DEBIN_SIGNED_EN
  assign bin_ready = (state == PREFIX) || (state == SUFFIX) || (state == SIGN);
`else
  assign bin_ready = (state == PREFIX) || (state == SUFFIX);
`endif

  assign accept    = bin_valid && bin_ready;
  assign val_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign value     = val_q;
  assign bin_len   = len;
  assign err       = err_q;

  assign pow     = {{VAL_BITS{1'b0}}, 1'b1} << k;
  assign psum    = {1'b0, acc} + pow;
  assign suff_sh = {suff[VAL_BITS-2:0], bin};
  assign fsum    = {1'b0, acc} + {1'b0, suff_sh};
  // Any suffix bit shifted past the value width, or a carry on the final add, is an overflow
  assign sfx_err = ovf | suff[VAL_BITS-1] | fsum[VAL_BITS];

  always_comb begin
    state_nx = state;
    k_nx     = k;
    cnt_nx   = cnt;
    acc_nx   = acc;
    suff_nx  = suff;
    ovf_nx   = ovf;
    len_nx   = len;
    val_nx   = val_q;
    err_nx   = err_q;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = PREFIX;
          k_nx     = {{(KW-4){1'b0}}, K};
          cnt_nx   = '0;
          acc_nx   = '0;
          suff_nx  = '0;
          ovf_nx   = 1'b0;
          len_nx   = '0;
          err_nx   = 1'b0;
        end
      end
      PREFIX: begin
        if (accept) begin
          len_nx = len + LEN_BITS'(1);
          if (bin) begin
            val_nx = psum[VAL_BITS-1:0];
            if ((k >= K_LIMIT) || psum[VAL_BITS]) begin
              err_nx   = 1'b1;
              state_nx = DONE;
            end else begin
              acc_nx = psum[VAL_BITS-1:0];
              k_nx   = k + KW'(1);
            end
          end else if (k == '0) begin
            val_nx   = acc;
            state_nx = (acc != '0) ? TAIL : DONE;
          end else begin
            cnt_nx   = k;
            state_nx = SUFFIX;
          end
        end
      end
      SUFFIX: begin
        if (accept) begin
          len_nx  = len + LEN_BITS'(1);
          suff_nx = suff_sh;
          ovf_nx  = ovf | suff[VAL_BITS-1];
          cnt_nx  = cnt - KW'(1);
          if (cnt == KW'(1)) begin
            val_nx   = fsum[VAL_BITS-1:0];
            err_nx   = sfx_err;
            state_nx = (!sfx_err && (fsum[VAL_BITS-1:0] != '0)) ? TAIL : DONE;
          end
        end
      end
`ifdef EGK_DEBIN_SIGNED_EN
      SIGN: begin
        if (accept) begin
          len_nx   = len + LEN_BITS'(1);
          state_nx = DONE;
          if (bin) begin
            val_nx = -val_q;
            err_nx = (val_q > HALF);
          end
        end
      end
`endif
      DONE: begin
        if (val_ready) begin
          state_nx = IDLE;
          err_nx   = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
    // Abort wins over any handshake in the same cycle
    if (flush && (state != IDLE)) begin
      state_nx = IDLE;
      err_nx   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      k     <= '0;
      cnt   <= '0;
      acc   <= '0;
      suff  <= '0;
      ovf   <= 1'b0;
      len   <= '0;
      val_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      k     <= k_nx;
      cnt   <= cnt_nx;
      acc   <= acc_nx;
      suff  <= suff_nx;
      ovf   <= ovf_nx;
      len   <= len_nx;
      val_q <= val_nx;
      err_q <= err_nx;
    end
  end

endmodule
